// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC record serializer: record layout,
// frame geometry and the serializer FSM encoding.
package lpc_pkg;

    localparam int         REC_W       = 44;
    localparam int         FRAME_LEN   = 7;
    localparam int         FRAME_W     = FRAME_LEN * 8;
    localparam int         IDX_W       = $clog2(FRAME_LEN);
    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam int         OVF_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    typedef struct packed {
        logic [3:0]  cyctype_dir;
        logic [31:0] addr;
        logic [7:0]  data;
    } rec_t;

    // b0 = sync|cyctype, b1..b4 = addr MSB first, b5 = data, b6 = XOR of b0..b5.
    function automatic logic [FRAME_W-1:0] build_frame(input rec_t r);
        logic [7:0] b0;
        logic [7:0] chk;
        b0  = {SYNC_NIBBLE, r.cyctype_dir};
        chk = b0 ^ r.addr[31:24] ^ r.addr[23:16] ^ r.addr[15:8] ^ r.addr[7:0] ^ r.data;
        return {b0, r.addr, r.data, chk};
    endfunction

endpackage

// File: rtl/lpc_record_serializer_if.sv
// Decoder-side record inputs and byte-sink outputs of the serializer.
interface lpc_record_serializer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       in_cyctype_dir;
    logic [31:0]      in_addr;
    logic [7:0]       in_data;
    logic             in_clock_enable;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic [7:0]       out_overflow_count;
    logic [LVL_W-1:0] out_fifo_level;

    modport master (
        output in_cyctype_dir, in_addr, in_data, in_clock_enable, out_ready,
        input  out_byte, out_valid, out_overflow_count, out_fifo_level
    );

    modport slave (
        input  in_cyctype_dir, in_addr, in_data, in_clock_enable, out_ready,
        output out_byte, out_valid, out_overflow_count, out_fifo_level
    );
endinterface

// File: rtl/lpc_record_fifo.sv
// Synchronous record FIFO; head word is visible combinationally on rdata.
// Pushes while full and pops while empty are ignored.
module lpc_record_fifo
    import lpc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [REC_W-1:0]       wdata,
    input  logic                   pop,
    output logic [REC_W-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Level carries the extra bit, so full and empty never alias when pointers match.
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lpc_record_serializer.sv
// Captures one LPC record per rising edge of the decoder valid level, queues it,
// and streams each record as a 7-byte checksummed frame over a valid/ready port.
module lpc_record_serializer
    import lpc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    lpc_clock,
    input  logic                    reset,
    lpc_record_serializer_if.slave  bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic               prev_en;
    logic               capture;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [LVL_W-1:0]   level;
    rec_t               head;
    rec_t               rec_q;
    logic [FRAME_W-1:0] sh_q;
    logic [IDX_W-1:0]   idx_q;
    logic [OVF_W-1:0]   ovf_q;
    logic               xfer;
    state_t             state_q;
    state_t             state_d;

    // prev_en resets high so a level already asserted at reset release is ignored.
    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) prev_en <= 1'b1;
        else       prev_en <= bus.in_clock_enable;
    end

    assign capture = bus.in_clock_enable & ~prev_en;

    lpc_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (lpc_clock),
        .rst   (reset),
        .push  (capture),
        .wdata ({bus.in_cyctype_dir, bus.in_addr, bus.in_data}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Drop decision uses the pre-cycle full flag, even if a pop frees a slot this cycle.
    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset)
            ovf_q <= '0;
        else if (capture && fifo_full && (ovf_q != '1))
            ovf_q <= ovf_q + OVF_W'(1);
    end

    assign xfer = (state_q == ST_SEND) & bus.out_ready;

    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (xfer && (idx_q == IDX_W'(FRAME_LEN - 1))) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The popped record is held locally so later pushes cannot disturb the frame in flight.
    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            rec_q <= '0;
            sh_q  <= '0;
            idx_q <= '0;
        end else begin
            if (pop) rec_q <= head;
            if (state_q == ST_LOAD) begin
                sh_q  <= build_frame(rec_q);
                idx_q <= '0;
            end else if (xfer) begin
                sh_q  <= sh_q << 8;
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.out_valid          = (state_q == ST_SEND);
    assign bus.out_byte           = bus.out_valid ? sh_q[FRAME_W-1 -: 8] : 8'h00;
    assign bus.out_overflow_count = ovf_q;
    assign bus.out_fifo_level     = level;

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Directed bench for lpc_record_serializer: inputs driven and outputs sampled on
// the falling edge; all expected bytes and counts are hand-computed constants.
module tb_lpc_record_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lpc_record_serializer_if #(.FIFO_DEPTH(4)) bus ();

    lpc_record_serializer #(.FIFO_DEPTH(4)) dut (
        .lpc_clock (clk),
        .reset     (rst),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle enable pulse followed by one low cycle; call on a falling edge.
    task automatic pulse(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
        bus.in_cyctype_dir  = ct;
        bus.in_addr         = a;
        bus.in_data         = d;
        bus.in_clock_enable = 1'b1;
        tick(1);
        bus.in_clock_enable = 1'b0;
        tick(1);
    endtask

    // A2 ^ 00 ^ 00 ^ 00 ^ 80 ^ 55 = 77
    logic [7:0] exp_f [7] = '{8'hA2, 8'h00, 8'h00, 8'h00, 8'h80, 8'h55, 8'h77};

    initial begin
        int n_xfer;
        int n_vld;
        logic [7:0] last_b;

        bus.in_cyctype_dir  = 4'h0;
        bus.in_addr         = 32'h0;
        bus.in_data         = 8'h0;
        bus.in_clock_enable = 1'b0;
        bus.out_ready       = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_byte",  32'(bus.out_byte), 32'd0);
        check("rst_level", 32'(bus.out_fifo_level), 32'd0);
        check("rst_ovf",   32'(bus.out_overflow_count), 32'd0);

        // Single record: enable seen at edge N, b0 visible after edge N+2.
        bus.in_cyctype_dir  = 4'h2;
        bus.in_addr         = 32'h0000_0080;
        bus.in_data         = 8'h55;
        bus.in_clock_enable = 1'b1;
        tick(1);
        bus.in_clock_enable = 1'b0;
        check("single_n_valid", 32'(bus.out_valid), 32'd0);
        check("single_n_level", 32'(bus.out_fifo_level), 32'd1);
        tick(1);
        check("single_n1_valid", 32'(bus.out_valid), 32'd0);
        check("single_n1_level", 32'(bus.out_fifo_level), 32'd0);
        tick(1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("single_b%0d", i), {23'd0, bus.out_valid, bus.out_byte}, {23'd0, 1'b1, exp_f[i]});
            tick(1);
        end
        check("single_done", 32'(bus.out_valid), 32'd0);
        tick(3);

        // Backpressure: b0 held for 5 cycles with ready low, then frame completes.
        bus.out_ready       = 1'b0;
        bus.in_clock_enable = 1'b1;
        tick(1);
        bus.in_clock_enable = 1'b0;
        tick(2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d", k), {23'd0, bus.out_valid, bus.out_byte}, {23'd0, 1'b1, 8'hA2});
            if (k < 4) tick(1);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 7; i++) begin
            tick(1);
            check($sformatf("bp_b%0d", i), {23'd0, bus.out_valid, bus.out_byte}, {23'd0, 1'b1, exp_f[i]});
        end
        tick(1);
        check("bp_done", 32'(bus.out_valid), 32'd0);
        tick(3);

        // Overflow: one in flight, four queued, sixth dropped.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(4'h2, 32'h1000_0000 + 32'(i), 8'(i));
        check("ovf_level", 32'(bus.out_fifo_level), 32'd4);
        check("ovf_count", 32'(bus.out_overflow_count), 32'd1);
        check("ovf_b0", {23'd0, bus.out_valid, bus.out_byte}, {23'd0, 1'b1, 8'hA2});

        // Reset mid-frame after b2 transfers; enable held high across release.
        bus.out_ready = 1'b1;
        tick(1);
        check("mid_b1", 32'(bus.out_byte), 32'h10);
        tick(1);
        check("mid_b2", 32'(bus.out_byte), 32'h00);
        tick(1);
        rst = 1'b1;
        bus.in_clock_enable = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_level", 32'(bus.out_fifo_level), 32'd0);
        check("mid_rst_ovf",   32'(bus.out_overflow_count), 32'd0);
        tick(2);
        rst = 1'b0;
        n_vld = 0;
        for (int k = 0; k < 15; k++) begin
            if (k == 10) bus.in_clock_enable = 1'b0;
            tick(1);
            if (bus.out_valid) n_vld++;
        end
        check("post_rst_quiet", 32'(n_vld), 32'd0);

        // Level held high for 10 cycles yields exactly one frame.
        // Checksum: A3^DE^AD^BE^EF^01 = 80
        bus.in_cyctype_dir  = 4'h3;
        bus.in_addr         = 32'hDEAD_BEEF;
        bus.in_data         = 8'h01;
        bus.in_clock_enable = 1'b1;
        n_xfer = 0;
        last_b = 8'h00;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) bus.in_clock_enable = 1'b0;
            tick(1);
            if (bus.out_valid && bus.out_ready) begin
                n_xfer++;
                last_b = bus.out_byte;
            end
        end
        check("hold_nbytes", 32'(n_xfer), 32'd7);
        check("hold_chk", 32'(last_b), 32'h80);

        // Saturation: five fill the pipe, then 300 dropped records.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(4'h1, 32'(i), 8'(i));
        check("sat_level", 32'(bus.out_fifo_level), 32'd4);
        check("sat_zero",  32'(bus.out_overflow_count), 32'd0);
        for (int i = 0; i < 254; i++) pulse(4'h1, 32'(i), 8'(i));
        check("sat_254", 32'(bus.out_overflow_count), 32'd254);
        pulse(4'h1, 32'h0, 8'h0);
        check("sat_255", 32'(bus.out_overflow_count), 32'd255);
        for (int i = 0; i < 45; i++) pulse(4'h1, 32'(i), 8'(i));
        check("sat_300", 32'(bus.out_overflow_count), 32'd255);
        check("sat_b0",  {23'd0, bus.out_valid, bus.out_byte}, {23'd0, 1'b1, 8'hA1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lpc_record_serializer.md
LPC_RECORD_SERIALIZER -- requirements
Module: lpc_record_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of queued records (power of two, >=2).
REQ-002 lpc_clock  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-high.
REQ-004 in_cyctype_dir  in  4  cycle type/direction from the LPC decoder.
REQ-005 in_addr  in  32  decoded address.
REQ-006 in_data  in  8  decoded data byte.
REQ-007 in_clock_enable  in  1  decoder record-valid level; 0->1 transition marks a new record.
REQ-008 out_ready  in  1  downstream byte sink ready.
REQ-009 out_byte  out  8  serialized byte.
REQ-010 out_valid  out  1  out_byte valid.
REQ-011 out_overflow_count  out  8  saturating count of dropped records.
REQ-012 out_fifo_level  out  $clog2(FIFO_DEPTH)+1  records currently queued, excluding the one being sent.

Function
REQ-013 Edge detect: register prev_en; capture when in_clock_enable=1 and prev_en=0; one capture per rising edge, regardless of how long the level stays high.
REQ-014 Capture writes {in_cyctype_dir, in_addr, in_data} (44 bits) into the FIFO at the end of the detecting cycle N.
REQ-015 Full check uses pre-cycle state: a capture while the FIFO is full is dropped even if a pop occurs in the same cycle; out_overflow_count increments by 1 and saturates at 255.
REQ-016 A simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
REQ-017 Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by the extra level bit.
REQ-018 FSM states: IDLE, LOAD, SEND.
REQ-019 IDLE: if the FIFO is non-empty, pop the head and go to LOAD; otherwise stay.
REQ-020 LOAD: build a 7-byte frame in the shift register, set byte index to 0, go to SEND.
REQ-021 Frame bytes: b0={4'hA,cyctype_dir}; b1..b4=addr[31:24],[23:16],[15:8],[7:0]; b5=data; b6=XOR of b0..b5.
REQ-022 SEND: out_valid=1, out_byte=current byte.
REQ-023 SEND transfer: a byte transfers on a cycle with out_valid&out_ready, and the index then advances.
REQ-024 SEND exit: after b6 transfers, go to IDLE.
REQ-025 While out_valid=1 and out_ready=0, out_byte and out_valid hold stable.
REQ-026 Latency: edge seen in cycle N gives out_valid=1 with b0 in cycle N+2, when the FSM was IDLE with an empty FIFO.
REQ-027 out_valid=0 in IDLE and LOAD; the minimum gap between frames is 2 cycles.
REQ-028 A capture during SEND queues normally; the frame in flight is never modified.

Reset
REQ-029 Asynchronous assertion.
REQ-030 Reset values: state=IDLE, out_valid=0, out_byte=0, out_fifo_level=0, out_overflow_count=0, FIFO pointers=0, prev_en=1.
REQ-031 Because prev_en resets to 1, an in_clock_enable level already high when reset releases is not captured.
REQ-032 Reset mid-frame discards the partial frame and all queued records; no residual bytes are sent after release.

Structure
REQ-033 Shared package lpc_pkg holds: record width 44, frame length 7, sync nibble 4'hA, FSM state enum, overflow counter width 8.
REQ-034 Sub-module lpc_record_fifo: 44-bit synchronous FIFO with push, pop, full, empty and level, instantiated once.
REQ-035 The edge detector, FSM, shift register and overflow counter live in the top module.

Verification
REQ-036 Single record: I/O write cyctype 4'h2, addr 0x00000080, data 0x55, out_ready=1 -> bytes A2 00 00 00 80 55 77 on consecutive cycles, with b0 at N+2.
REQ-037 Backpressure: same record, out_ready=0 for 5 cycles after b0 appears -> out_byte=0xA2 and out_valid=1 held all 5 cycles; the frame then completes unchanged.
REQ-038 Overflow: 6 records spaced 2 cycles apart with out_ready=0 -> first in SEND, 4 queued (level=4), 6th dropped, out_overflow_count=1.
REQ-039 Level hold: in_clock_enable held high for 10 cycles -> exactly one 7-byte frame.
REQ-040 Reset mid-frame: assert reset after b2 transfers -> out_valid=0 immediately, level=0, count=0; nothing is sent after release until a new edge.
REQ-041 Saturation: 300 dropped records -> out_overflow_count stays at 255.
